// File: rtl/exe_pkg.sv
// Shared types for the ALU issue path: decoded-op entry, issue FSM states
// and branch-class opcode decode.
package exe_pkg;

    // Same encoding as the instruction header's opcode field.
    typedef logic [9:0] opcode_t;

    localparam int MASK_W = 64;

    typedef struct packed {
        opcode_t           opcode;
        logic [63:0]       oprd1;
        logic [63:0]       oprd2;
        logic [63:0]       oprd3;
        logic [63:0]       next_rip;
        logic [MASK_W-1:0] src_mask;
        logic [MASK_W-1:0] dst_mask;
        logic              rd_flags;
        logic              wr_flags;
    } exe_entry_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } issue_state_t;

    // Jcc short (0x70-0x7F), JMP short (0xEB), Jcc near (0x0F 0x80-0x8F).
    function automatic logic is_branch(opcode_t op);
        return op inside {[10'h070:10'h07F], 10'h0EB, [10'h180:10'h18F]};
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Small circular FIFO of decoded ops; the head entry is always visible so the
// issue logic can check hazards before popping.
module issue_fifo
    import exe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  exe_entry_t       push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o,
    output exe_entry_t       head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    exe_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps for free.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Decode-to-ALU issue controller: buffers ops, blocks on GPR/RFLAGS hazards
// via a scoreboard, serializes branches and flushes younger ops on taken.
module alu_issue_ctrl
    import exe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [9:0]       dec_opcode,
    input  logic [63:0]      dec_oprd1,
    input  logic [63:0]      dec_oprd2,
    input  logic [63:0]      dec_oprd3,
    input  logic [63:0]      dec_next_rip,
    input  logic [NREGS-1:0] dec_src_mask,
    input  logic [NREGS-1:0] dec_dst_mask,
    input  logic             dec_rd_flags,
    input  logic             dec_wr_flags,
    output logic             alu_enable,
    output logic [9:0]       alu_opcode,
    output logic [63:0]      alu_oprd1,
    output logic [63:0]      alu_oprd2,
    output logic [63:0]      alu_oprd3,
    output logic [63:0]      alu_next_rip,
    input  logic             mem_blocked,
    input  logic             wb_valid,
    input  logic [NREGS-1:0] wb_dst_mask,
    input  logic             wb_flags,
    input  logic             br_resolved,
    input  logic             br_taken,
    input  logic [63:0]      br_target,
    output logic             flush,
    output logic [63:0]      flush_rip,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic [NREGS-1:0] dbg_sb_gpr
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    issue_state_t      state_q;
    logic              flush_q;
    logic [63:0]       flush_rip_q;
    logic [NREGS-1:0]  sb_gpr_q, sb_gpr_d;
    logic              sb_flags_q, sb_flags_d;
    logic              alu_enable_q;
    logic [9:0]        alu_opcode_q;
    logic [63:0]       alu_oprd1_q, alu_oprd2_q, alu_oprd3_q, alu_next_rip_q;

    exe_entry_t        push_entry;
    exe_entry_t        head;
    logic [CNT_W-1:0]  count;
    logic [MASK_W-1:0] sb_gpr_ext;
    logic              hazard, slot_free, issue, resolve_taken, clear, push;

    // Handshakes: an op moves from decode when dec_valid && dec_ready at a
    // rising edge; an ALU op is consumed at the first edge with alu_enable
    // high and mem_blocked low, and alu_* hold steady until then.
    assign dec_ready = !reset && (count < CNT_W'(DEPTH)) && (state_q != FLUSH);

    always_comb begin
        push_entry                     = '0;
        push_entry.opcode              = dec_opcode;
        push_entry.oprd1               = dec_oprd1;
        push_entry.oprd2               = dec_oprd2;
        push_entry.oprd3               = dec_oprd3;
        push_entry.next_rip            = dec_next_rip;
        push_entry.src_mask[NREGS-1:0] = dec_src_mask;
        push_entry.dst_mask[NREGS-1:0] = dec_dst_mask;
        push_entry.rd_flags            = dec_rd_flags;
        push_entry.wr_flags            = dec_wr_flags;

        sb_gpr_ext              = '0;
        sb_gpr_ext[NREGS-1:0]   = sb_gpr_q;
        hazard    = (|((head.src_mask | head.dst_mask) & sb_gpr_ext))
                 || ((head.rd_flags || head.wr_flags) && sb_flags_q);
        slot_free = !alu_enable_q || !mem_blocked;
        issue     = (count != '0) && !hazard && (state_q == RUN) && slot_free;

        // Ops accepted on the resolving edge are younger than the branch.
        resolve_taken = (state_q == BR_WAIT) && br_resolved && br_taken;
        clear         = resolve_taken || (state_q == FLUSH);
        push          = dec_valid && dec_ready && !clear;

        // Retire first, then issue, so a same-edge set wins over the clear.
        sb_gpr_d   = sb_gpr_q;
        sb_flags_d = sb_flags_q;
        if (wb_valid) begin
            sb_gpr_d = sb_gpr_d & ~wb_dst_mask;
            if (wb_flags) begin
                sb_flags_d = 1'b0;
            end
        end
        if (issue) begin
            sb_gpr_d = sb_gpr_d | head.dst_mask[NREGS-1:0];
            if (head.wr_flags) begin
                sb_flags_d = 1'b1;
            end
        end
    end

    issue_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (issue),
        .clear_i     (clear),
        .count_o     (count),
        .head_o      (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_q     <= 1'b0;
            flush_rip_q <= '0;
        end else begin
            flush_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (issue && is_branch(head.opcode)) begin
                        state_q <= BR_WAIT;
                    end
                end
                BR_WAIT: begin
                    if (br_resolved) begin
                        if (br_taken) begin
                            state_q     <= FLUSH;
                            flush_q     <= 1'b1;
                            flush_rip_q <= br_target;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                FLUSH:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_gpr_q       <= '0;
            sb_flags_q     <= 1'b0;
            alu_enable_q   <= 1'b0;
            alu_opcode_q   <= '0;
            alu_oprd1_q    <= '0;
            alu_oprd2_q    <= '0;
            alu_oprd3_q    <= '0;
            alu_next_rip_q <= '0;
        end else begin
            sb_gpr_q   <= sb_gpr_d;
            sb_flags_q <= sb_flags_d;
            if (issue) begin
                alu_enable_q   <= 1'b1;
                alu_opcode_q   <= head.opcode;
                alu_oprd1_q    <= head.oprd1;
                alu_oprd2_q    <= head.oprd2;
                alu_oprd3_q    <= head.oprd3;
                alu_next_rip_q <= head.next_rip;
            end else if (alu_enable_q && !mem_blocked) begin
                alu_enable_q <= 1'b0;
            end
        end
    end

    assign alu_enable   = alu_enable_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_oprd1    = alu_oprd1_q;
    assign alu_oprd2    = alu_oprd2_q;
    assign alu_oprd3    = alu_oprd3_q;
    assign alu_next_rip = alu_next_rip_q;
    assign flush        = flush_q;
    assign flush_rip    = flush_rip_q;
    assign busy         = (count != '0) || alu_enable_q || (sb_gpr_q != '0) || sb_flags_q;
    assign dbg_state    = state_q;
    assign dbg_sb_gpr   = sb_gpr_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: table of single-op vectors, directed corner-case
// sequences, then random traffic against a queue-based reference model.
module tb_alu_issue_ctrl;
  import exe_pkg::*;

  localparam int DEPTH = 2;
  localparam int NREGS = 16;

  logic clk = 1'b0;
  logic reset;
  logic dec_valid, dec_ready;
  logic [9:0] dec_opcode;
  logic [63:0] dec_oprd1, dec_oprd2, dec_oprd3, dec_next_rip;
  logic [NREGS-1:0] dec_src_mask, dec_dst_mask;
  logic dec_rd_flags, dec_wr_flags;
  logic alu_enable;
  logic [9:0] alu_opcode;
  logic [63:0] alu_oprd1, alu_oprd2, alu_oprd3, alu_next_rip;
  logic mem_blocked, wb_valid;
  logic [NREGS-1:0] wb_dst_mask;
  logic wb_flags, br_resolved, br_taken;
  logic [63:0] br_target;
  logic flush;
  logic [63:0] flush_rip;
  logic busy;
  logic [1:0] dbg_state;
  logic [NREGS-1:0] dbg_sb_gpr;

  alu_issue_ctrl #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_oprd1(dec_oprd1), .dec_oprd2(dec_oprd2), .dec_oprd3(dec_oprd3),
    .dec_next_rip(dec_next_rip), .dec_src_mask(dec_src_mask), .dec_dst_mask(dec_dst_mask),
    .dec_rd_flags(dec_rd_flags), .dec_wr_flags(dec_wr_flags),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_oprd3(alu_oprd3),
    .alu_next_rip(alu_next_rip), .mem_blocked(mem_blocked),
    .wb_valid(wb_valid), .wb_dst_mask(wb_dst_mask), .wb_flags(wb_flags),
    .br_resolved(br_resolved), .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .flush_rip(flush_rip), .busy(busy),
    .dbg_state(dbg_state), .dbg_sb_gpr(dbg_sb_gpr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0]  opc;
    logic [63:0] o1, o2, o3, rip;
    logic [15:0] src, dst;
    logic        rf, wf;
  } op_t;

  typedef struct packed {
    logic [9:0]  opc;
    logic [15:0] src, dst;
    logic        rf, wf;
    logic [15:0] exp_sb;
    logic [1:0]  exp_st;
  } vec_t;

  // ---------------- reference model state ----------------
  op_t         mq[$];
  op_t         m_alu;
  logic        m_en;
  logic [15:0] m_sb;
  logic        m_sbf;
  bit          m_wait, m_flush;
  logic [63:0] m_frip;
  logic [63:0] exp_q[$];
  op_t         cur_op;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    dec_valid = 0; dec_opcode = '0; dec_oprd1 = '0; dec_oprd2 = '0; dec_oprd3 = '0;
    dec_next_rip = '0; dec_src_mask = '0; dec_dst_mask = '0;
    dec_rd_flags = 0; dec_wr_flags = 0; mem_blocked = 0; wb_valid = 0;
    wb_dst_mask = '0; wb_flags = 0; br_resolved = 0; br_taken = 0; br_target = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_in();
    tick();
    reset = 0;
    #1;
  endtask

  function automatic op_t mk(logic [9:0] opc, logic [15:0] src, logic [15:0] dst,
                             logic [63:0] rip);
    op_t o;
    o.opc = opc; o.src = src; o.dst = dst; o.rf = 0; o.wf = 0;
    o.rip = rip; o.o1 = rip ^ 64'hA5A5_0000_1111_0000;
    o.o2 = rip + 64'd7; o.o3 = ~rip;
    return o;
  endfunction

  task automatic put_op(op_t o);
    dec_opcode = o.opc; dec_oprd1 = o.o1; dec_oprd2 = o.o2; dec_oprd3 = o.o3;
    dec_next_rip = o.rip; dec_src_mask = o.src; dec_dst_mask = o.dst;
    dec_rd_flags = o.rf; dec_wr_flags = o.wf;
  endtask

  function automatic bit tb_is_branch(logic [9:0] o);
    return (o >= 10'h070 && o <= 10'h07F) || o == 10'h0EB || (o >= 10'h180 && o <= 10'h18F);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic m_ready();
    return !reset && (mq.size() < DEPTH) && !m_flush;
  endfunction

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    m_alu = '0; m_en = 0; m_sb = '0; m_sbf = 0; m_wait = 0; m_flush = 0; m_frip = '0;
  endtask

  task automatic compare_model();
    check("dec_ready", dec_ready, m_ready());
    check("alu_enable", alu_enable, m_en);
    check("alu_opcode", alu_opcode, m_alu.opc);
    check("alu_oprd1", alu_oprd1, m_alu.o1);
    check("alu_oprd2", alu_oprd2, m_alu.o2);
    check("alu_oprd3", alu_oprd3, m_alu.o3);
    check("alu_next_rip", alu_next_rip, m_alu.rip);
    check("flush", flush, m_flush);
    check("flush_rip", flush_rip, m_frip);
    check("busy", busy, (mq.size() != 0) || m_en || (m_sb != 0) || m_sbf);
  endtask

  // Advances the model across the coming edge using the inputs now driven.
  task automatic model_step();
    bit   rdy, iss, taken;
    op_t  h;
    if (reset) begin
      model_reset();
      return;
    end
    if (alu_enable && !mem_blocked) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL consume_order actual=0x%0h expected=none @%0t", alu_next_rip, $time);
      end else begin
        check("consume_order", alu_next_rip, exp_q.pop_front());
      end
    end
    rdy = m_ready();
    iss = 0;
    h = '0;
    if (mq.size() > 0 && !m_wait && !m_flush && (!m_en || !mem_blocked)) begin
      h = mq[0];
      iss = (((h.src | h.dst) & m_sb) == 0) && !((h.rf || h.wf) && m_sbf);
    end
    taken = m_wait && br_resolved && br_taken;
    if (wb_valid) begin
      m_sb = m_sb & ~wb_dst_mask;
      if (wb_flags) m_sbf = 0;
    end
    if (iss) begin
      m_sb = m_sb | h.dst;
      if (h.wf) m_sbf = 1;
      m_alu = h;
      m_en = 1;
      void'(mq.pop_front());
      exp_q.push_back(h.rip);
    end else if (m_en && !mem_blocked) begin
      m_en = 0;
    end
    if (dec_valid && rdy && !taken) mq.push_back(cur_op);
    if (m_flush) begin
      m_flush = 0;
    end else if (taken) begin
      m_flush = 1; m_frip = br_target; m_wait = 0; mq.delete();
    end else if (m_wait && br_resolved) begin
      m_wait = 0;
    end else if (iss && tb_is_branch(h.opc)) begin
      m_wait = 1;
    end
  endtask

  function automatic logic [15:0] rand_mask();
    case ($urandom_range(0, 7))
      0, 1, 2: return 16'h0000;
      7:       return 16'(1 << $urandom_range(0, 15));
      default: return 16'(1 << $urandom_range(0, 3));
    endcase
  endfunction

  function automatic logic [9:0] rand_opc();
    case ($urandom_range(0, 11))
      0:       return 10'h070 + 10'($urandom_range(0, 15));
      1:       return 10'h0EB;
      2:       return 10'h180 + 10'($urandom_range(0, 15));
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  // ---------------- test ----------------
  vec_t tbl[8];
  op_t  x, y, z, w, b;

  initial begin
    tbl[0] = '{10'h001, 16'h0008, 16'h0001, 1'b0, 1'b0, 16'h0001, RUN};
    tbl[1] = '{10'h074, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, BR_WAIT};
    tbl[2] = '{10'h0EB, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, BR_WAIT};
    tbl[3] = '{10'h18F, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, BR_WAIT};
    tbl[4] = '{10'h06F, 16'h0002, 16'h0004, 1'b0, 1'b1, 16'h0004, RUN};
    tbl[5] = '{10'h080, 16'h0000, 16'h0010, 1'b0, 1'b0, 16'h0010, RUN};
    tbl[6] = '{10'h190, 16'h0001, 16'h8000, 1'b0, 1'b1, 16'h8000, RUN};
    tbl[7] = '{10'h17F, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, RUN};

    // Reset values while reset is held, then dec_ready the cycle after.
    reset = 1;
    clear_in();
    tick();
    check("rst_dec_ready", dec_ready, 0);
    check("rst_alu_enable", alu_enable, 0);
    check("rst_alu_opcode", alu_opcode, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_rip", flush_rip, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    #1;
    check("rst_release_ready", dec_ready, 1);

    // Table: single op into idle block, issues exactly one edge after push.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      x = mk(tbl[i].opc, tbl[i].src, tbl[i].dst, 64'h1000 + 64'(i));
      x.rf = tbl[i].rf; x.wf = tbl[i].wf;
      put_op(x);
      dec_valid = 1;
      tick();
      dec_valid = 0;
      check($sformatf("tbl%0d_not_yet", i), alu_enable, 0);
      tick();
      check($sformatf("tbl%0d_enable", i), alu_enable, 1);
      check($sformatf("tbl%0d_opcode", i), alu_opcode, tbl[i].opc);
      check($sformatf("tbl%0d_rip", i), alu_next_rip, x.rip);
      check($sformatf("tbl%0d_sb", i), dbg_sb_gpr, tbl[i].exp_sb);
      check($sformatf("tbl%0d_state", i), dbg_state, tbl[i].exp_st);
      tick();
      check($sformatf("tbl%0d_drop", i), alu_enable, 0);
    end

    // RAW hazard: OR reading RAX waits for the ADD writeback.
    do_reset();
    put_op(mk(10'h001, 16'h0008, 16'h0001, 64'h100)); dec_valid = 1;
    tick();
    put_op(mk(10'h009, 16'h0001, 16'h0000, 64'h104));
    tick();
    dec_valid = 0;
    check("raw_add_issue", alu_opcode, 10'h001);
    tick(); tick();
    check("raw_or_held", alu_enable, 0);
    check("raw_sb_held", dbg_sb_gpr, 16'h0001);
    wb_valid = 1; wb_dst_mask = 16'h0001;
    tick();
    wb_valid = 0; wb_dst_mask = '0;
    check("raw_not_same_edge", alu_enable, 0);
    tick();
    check("raw_or_enable", alu_enable, 1);
    check("raw_or_opcode", alu_opcode, 10'h009);

    // Memory stall: outputs hold, FIFO fills, dec_ready drops.
    do_reset();
    x = mk(10'h001, 0, 0, 64'h10); y = mk(10'h002, 0, 0, 64'h20);
    z = mk(10'h003, 0, 0, 64'h30); w = mk(10'h004, 0, 0, 64'h40);
    put_op(x); dec_valid = 1;
    tick();
    put_op(y);
    tick();
    check("stall_x_issue", alu_opcode, 10'h001);
    mem_blocked = 1; put_op(z);
    for (int c = 0; c < 3; c++) begin
      tick();
      put_op(w);
      check($sformatf("stall_hold_op%0d", c), alu_opcode, 10'h001);
      check($sformatf("stall_hold_o1_%0d", c), alu_oprd1, x.o1);
      check($sformatf("stall_hold_en%0d", c), alu_enable, 1);
      check($sformatf("stall_ready%0d", c), dec_ready, 0);
    end
    mem_blocked = 0; dec_valid = 0;
    tick();
    check("stall_y_issue", alu_opcode, 10'h002);
    check("stall_ready_back", dec_ready, 1);
    tick();
    check("stall_z_issue", alu_opcode, 10'h003);
    tick();
    check("stall_drain_en", alu_enable, 0);
    check("stall_drain_busy", busy, 0);

    // Branch not taken: buffered ops issue back to back, no flush.
    do_reset();
    put_op(mk(10'h074, 0, 0, 64'h200)); dec_valid = 1;
    tick();
    put_op(mk(10'h011, 0, 0, 64'h202));
    tick();
    put_op(mk(10'h012, 0, 0, 64'h204));
    tick();
    dec_valid = 0; br_resolved = 1; br_taken = 0;
    tick();
    br_resolved = 0;
    check("bnt_wait_idle", alu_enable, 0);
    check("bnt_flush0", flush, 0);
    tick();
    check("bnt_a_opcode", alu_opcode, 10'h011);
    check("bnt_a_en", alu_enable, 1);
    check("bnt_flush1", flush, 0);
    tick();
    check("bnt_b_opcode", alu_opcode, 10'h012);
    check("bnt_b_en", alu_enable, 1);

    // Branch taken: one-cycle flush, buffered and flush-cycle ops dropped.
    do_reset();
    put_op(mk(10'h0EB, 0, 0, 64'h300)); dec_valid = 1;
    tick();
    put_op(mk(10'h021, 0, 0, 64'h302));
    tick();
    dec_valid = 0; br_resolved = 1; br_taken = 1; br_target = 64'h400100;
    tick();
    br_resolved = 0; br_taken = 0; br_target = '0;
    check("bt_flush", flush, 1);
    check("bt_flush_rip", flush_rip, 64'h400100);
    check("bt_ready_low", dec_ready, 0);
    check("bt_fifo_empty", busy, 0);
    put_op(mk(10'h022, 0, 0, 64'h304)); dec_valid = 1;
    tick();
    dec_valid = 0;
    check("bt_flush_end", flush, 0);
    check("bt_ready_back", dec_ready, 1);
    check("bt_drop_in_flush", busy, 0);
    tick();
    check("bt_no_issue", alu_enable, 0);

    // Reset mid-operation: FIFO full, BR_WAIT, op held by mem_blocked.
    do_reset();
    b = mk(10'h070, 0, 16'h0002, 64'h500);
    put_op(b); dec_valid = 1;
    tick();
    put_op(mk(10'h031, 0, 0, 64'h502));
    tick();
    mem_blocked = 1;
    put_op(mk(10'h032, 0, 0, 64'h504));
    tick();
    dec_valid = 0;
    check("mid_full", dec_ready, 0);
    check("mid_state", dbg_state, BR_WAIT);
    check("mid_sb", dbg_sb_gpr, 16'h0002);
    reset = 1;
    #1;
    check("mid_rst_ready", dec_ready, 0);
    tick();
    mem_blocked = 0;
    reset = 0;
    check("mid_alu_enable", alu_enable, 0);
    check("mid_alu_opcode", alu_opcode, 0);
    check("mid_alu_oprd1", alu_oprd1, 0);
    check("mid_alu_rip", alu_next_rip, 0);
    check("mid_flush", flush, 0);
    check("mid_busy", busy, 0);
    check("mid_state_run", dbg_state, RUN);
    check("mid_sb_clear", dbg_sb_gpr, 0);
    #1;
    check("mid_ready_after", dec_ready, 1);

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      compare_model();
      reset = ($urandom_range(0, 299) == 0);
      cur_op = mk(rand_opc(), rand_mask(), rand_mask(), 64'h8000 + 64'(cyc) * 4);
      cur_op.o1 = {$urandom, $urandom};
      cur_op.rf = ($urandom_range(0, 3) == 0);
      cur_op.wf = ($urandom_range(0, 3) == 0);
      put_op(cur_op);
      dec_valid = ($urandom_range(0, 3) != 0);
      mem_blocked = ($urandom_range(0, 3) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_dst_mask = $urandom_range(0, 1) ? m_sb : 16'($urandom);
      wb_flags = ($urandom_range(0, 1) == 0);
      br_resolved = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      br_taken = $urandom_range(0, 1);
      br_target = {$urandom, $urandom};
      model_step();
    end
    @(negedge clk);
    compare_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller between decode and the ALU. Buffers decoded ops in a small FIFO and tracks in-flight GPR and RFLAGS writers with a scoreboard. Issues one op per cycle to the ALU when there is no hazard and memory is not blocked. Serializes conditional and unconditional jumps, and flushes younger buffered ops when a branch resolves taken.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries (power of two, ≥2)
- `NREGS`, 16: GPRs tracked by the scoreboard

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `dec_valid`  in  1  decoded op offered
- `dec_ready`  out  1  FIFO can accept; `!reset && count<DEPTH`
- `dec_opcode`  in  10  `opcode_t`
- `dec_oprd1`/`dec_oprd2`/`dec_oprd3`  in  64 each  operands
- `dec_next_rip`  in  64  rip of the following instruction
- `dec_src_mask`  in  NREGS  GPRs read
- `dec_dst_mask`  in  NREGS  GPRs written
- `dec_rd_flags`, `dec_wr_flags`  in  1  reads / writes RFLAGS
- `alu_enable`  out  1  op valid to ALU
- `alu_opcode`  out  10  to ALU
- `alu_oprd1..3`  out  64  to ALU
- `alu_next_rip`  out  64  to ALU
- `mem_blocked`  in  1  downstream stall
- `wb_valid`  in  1  writeback retiring
- `wb_dst_mask`  in  NREGS  GPRs retired
- `wb_flags`  in  1  RFLAGS retired
- `br_resolved`  in  1  one-cycle branch outcome pulse
- `br_taken`  in  1  qualified by `br_resolved`
- `br_target`  in  64  qualified by `br_resolved`
- `flush`  out  1  one-cycle redirect pulse
- `flush_rip`  out  64  redirect target
- `busy`  out  1  FIFO non-empty, `alu_enable` high, or scoreboard non-zero

## Operation
- **Push.** Push on `dec_valid && dec_ready`, except in state FLUSH, where input is dropped.
- **Head hazard** when any of these holds:
  - `(src|dst) & sb_gpr != 0`
  - `(rd_flags|wr_flags) && sb_flags`
- **Issue.** The head issues when the FIFO is non-empty, there is no hazard, state is RUN, and the output slot is free. The slot is free when `!alu_enable || !mem_blocked`.
  - Issue loads the `alu_*` registers, pops the head, and sets `alu_enable`.
  - Issue sets `sb_gpr |= dst` and `sb_flags |= wr_flags` in the same edge.
- **Output hold.** While `alu_enable && mem_blocked`, the `alu_*` outputs hold unchanged. The op counts as consumed at the first edge with `!mem_blocked`. `alu_enable` drops after that edge unless a new op issues.
- **Retire.** `wb_valid` clears `wb_dst_mask` and `wb_flags` bits. If the same bit is cleared and set in one edge, set wins.
- **Branch ops** are opcodes `0x70–0x7F`, `0xEB`, `0x180–0x18F`.
- **States:**
  - RUN → BR_WAIT on issuing a branch op.
  - BR_WAIT: no issue; pushes still allowed.
    - On `br_resolved && br_taken` → FLUSH. Capture `br_target` into `flush_rip`.
    - On `br_resolved && !br_taken` → RUN.
  - FLUSH, one cycle:
    - `flush=1`.
    - FIFO emptied; input dropped and `dec_ready=0`.
    - Scoreboard untouched, since older writers still retire.
    - Next state RUN.
- A `br_resolved` pulse in RUN or FLUSH is ignored.
- **Reset mid-operation** discards the FIFO, scoreboard, and any held ALU op.

## Timing
- **Reset values:**
  - `alu_enable=0`, `alu_*` data = 0
  - `flush=0`, `flush_rip=0`, `busy=0`
  - state RUN, FIFO empty, scoreboard 0
  - `dec_ready=0` while `reset=1`, 1 the cycle after
- **Latency.** An op pushed at edge N into an empty FIFO, with no hazard, drives `alu_enable=1` after edge N+1. There is no bypass, so throughput is 1 op/cycle.
- **Full.** With `count==DEPTH`, `dec_ready=0`. A pop in the same cycle does not raise `dec_ready`, because it is computed from the registered count.
- **Simultaneous push and pop** keep the count constant. Pointers wrap modulo `DEPTH`.
- **Retire timing.** `wb_valid` at edge N unblocks a dependent head that issues at edge N+1, not earlier.
- **Flush timing.** `flush` is high for the cycle after the resolving edge. Pushes resume the next cycle.

## Structure
- `exe_pkg` holds:
  - `exe_entry_t` struct (opcode, operands, next_rip, masks, flag bits)
  - `issue_state_t` enum {RUN, BR_WAIT, FLUSH}
  - `is_branch(opcode_t)` function
  - `opcode_t` comes from the existing instruction header.
- Sub-module `issue_fifo`: parameterized FIFO of `exe_entry_t` with push, pop, clear, count, and head outputs.

## Test plan
- **Basic issue.** Push ADD (dst=RAX bit0, src=RBX bit3) into the idle block → `alu_enable` is 1 exactly one cycle after the push, `alu_opcode=0x001`, and `sb_gpr=0x0001`.
- **RAW hazard.** Push ADD dst=0x0001, then OR src=0x0001 → OR holds until `wb_valid` with `wb_dst_mask=0x0001`, then issues on the next edge.
- **Memory stall.** Assert `mem_blocked` for 3 cycles while `alu_enable=1` → outputs stay stable, no pop, and `dec_ready` falls to 0 once 2 entries are buffered.
- **Branch not taken.** Issue `0x074`, push two ops, pulse `br_resolved` with `br_taken=0` → the two ops issue on consecutive cycles and `flush` stays 0.
- **Branch taken.** Issue `0x0EB`, push one op, pulse `br_taken=1` with `br_target=0x400100` → `flush=1` and `flush_rip=0x400100` for one cycle, the FIFO is empty, and the buffered op never issues.
- **Reset mid-operation.** Raise `reset` for 1 cycle with the FIFO full and in BR_WAIT → all outputs return to reset values, `busy=0`, and `dec_ready=1` the cycle after reset drops.
